// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP word and the queue entry type
// used by the instruction-fetch unit and its prefetch queue.
package fetch_pkg;

    localparam int INST_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: circular FIFO of fetch_entry_t with flush.
// Flush overrides push; head is the entry at the read pointer.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

    // Pointer, occupancy and storage update; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, ROM fetch control and prefetch queue to ID.
// Optional FETCH_STAT_EN macro adds fetch/flush performance counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_flush_cnt
`endif
);

    localparam int            CW   = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic          ce_q;
    fetch_entry_t  head;
    fetch_entry_t  hold_q;
    fetch_entry_t  push_data;
    logic [CW-1:0] count;
    logic          pop;
    logic          fetch;
    logic          unused_tgt;

    assign unused_tgt = ^br_target[1:0];

    assign rom_ce    = ce_q;
    assign rom_addr  = {pc_q[31:2], 2'b00};
    assign id_valid  = (count != '0);
    assign pop       = id_valid & id_ready;
    assign fetch     = ce_q & ~br_valid & ((count < FULL) | pop);
    assign push_data = '{pc: rom_addr, inst: rom_inst};

    // Empty queue keeps showing the last head seen by ID.
    assign id_inst = id_valid ? head.inst : hold_q.inst;
    assign id_pc   = id_valid ? head.pc   : hold_q.pc;

    // Next PC: redirect first, then sequential advance, else hold.
    always_comb begin
        pc_d = pc_q;
        if (br_valid) begin
            pc_d = {br_target[31:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + 32'(INST_BYTES);
        end
    end

    // PC, chip-enable and last-head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= {RESET_PC[31:2], 2'b00};
            ce_q   <= 1'b0;
            hold_q <= '{pc: 32'h0, inst: NOP};
        end else begin
            pc_q <= pc_d;
            ce_q <= 1'b1;
            if (id_valid) begin
                hold_q <= head;
            end
        end
    end

    if_fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (br_valid),
        .push      (fetch),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    assign stat_fetch_cnt = fetch_cnt_q;
    assign stat_flush_cnt = flush_cnt_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (br_valid) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule
